act_stream_unit: RTL

Parametrised streaming activation stage that sits between the convolution accumulators and the pooling layer. It replaces the fixed 8-channel, 24x24 array ReLU with a per-beat valid/ready stream of CH lanes. The activation mode is selectable per frame: bypass, ReLU, leaky ReLU or clipped ReLU. Results are saturated to a narrower output width, and the block counts a frame of FRAME_LEN beats and reports completion and any overflow.

---
 rtl/act_stream_unit_if.sv | 34 +++
 rtl/act_stream_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/act_stream_unit_if.sv
// Control, input-stream and output-stream signals of the activation stage.
interface act_stream_unit_if #(
  parameter int unsigned CH     = 8,
  parameter int unsigned DATA_W = 69,
  parameter int unsigned OUT_W  = 32
) ();

  logic                   start;
  logic [1:0]             mode;
  logic [DATA_W-2:0]      clip_val;
  logic                   in_valid;
  logic                   in_ready;
  logic [CH*DATA_W-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH*OUT_W-1:0]    out_data;
  logic                   out_last;
  logic                   busy;
  logic                   frame_done;
  logic                   sat_flag;

  // Upstream / controller side
  modport master (
    output start, mode, clip_val, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, frame_done, sat_flag
  );

  // Activation stage side
  modport slave (
    input  start, mode, clip_val, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, frame_done, sat_flag
  );

endinterface

// File: rtl/act_stream_unit.sv
// Streaming CH-lane activation stage: bypass / ReLU / leaky / clipped ReLU,
// then signed saturation to OUT_W, framed in FRAME_LEN beats.
module act_stream_unit #(
  parameter int unsigned CH          = 8,
  parameter int unsigned DATA_W      = 69,
  parameter int unsigned OUT_W       = 32,
  parameter int unsigned FRAME_LEN   = 576,
  parameter int unsigned LEAKY_SHIFT = 3,
  parameter int unsigned CNT_W       = $clog2(FRAME_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  act_stream_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       in_cnt;
  logic [CNT_W-1:0]       out_cnt;
  logic [1:0]             cfg_mode;
  logic [DATA_W-2:0]      cfg_clip;
  logic                   busy_q;
  logic                   done_q;
  logic                   sat_q;

  logic                   s1_valid;
  logic [CH*DATA_W-1:0]   s1_data;
  logic                   s2_valid;
  logic [CH*OUT_W-1:0]    s2_data;

  logic                   adv;
  logic                   in_fire;
  logic                   out_fire;
  logic                   out_last_w;
  logic [CH*DATA_W-1:0]   s1_next;
  logic [CH*OUT_W-1:0]    s2_next;
  logic                   sat_any;

  // Per-lane activation on a signed DATA_W element
  function automatic logic [DATA_W-1:0] act_fn(input logic [DATA_W-1:0] x,
                                               input logic [1:0]        m,
                                               input logic [DATA_W-2:0] clip);
    logic [DATA_W-1:0] clip_x;
    clip_x = {1'b0, clip};
    act_fn = x;
    case (m)
      2'd1: if (x[DATA_W-1]) act_fn = '0;
      2'd2: if (x[DATA_W-1]) act_fn = DATA_W'($signed(x) >>> LEAKY_SHIFT);
      2'd3: begin
        if (x[DATA_W-1])     act_fn = '0;
        else if (x > clip_x) act_fn = clip_x;
      end
      default: act_fn = x;
    endcase
  endfunction

  // True when y does not fit in a signed OUT_W value
  function automatic logic sat_hit(input logic [DATA_W-1:0] y);
    sat_hit = !((&y[DATA_W-1:OUT_W-1]) || !(|y[DATA_W-1:OUT_W-1]));
  endfunction

  // Signed saturation of y down to OUT_W
  function automatic logic [OUT_W-1:0] sat_fn(input logic [DATA_W-1:0] y);
    if (sat_hit(y))
      sat_fn = y[DATA_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      sat_fn = y[OUT_W-1:0];
  endfunction

  assign adv        = !s2_valid || bus.out_ready;
  assign in_fire    = bus.in_valid && bus.in_ready;
  assign out_fire   = s2_valid && bus.out_ready;
  assign out_last_w = s2_valid && (out_cnt == CNT_W'(FRAME_LEN - 1));

  assign bus.in_ready   = (state == RUN) && adv;
  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_last   = out_last_w;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.sat_flag   = sat_q;

  // Lane datapath for both stages plus any-lane clamp detect
  always_comb begin
    s1_next = '0;
    s2_next = '0;
    sat_any = 1'b0;
    for (int k = 0; k < int'(CH); k++) begin
      s1_next[k*DATA_W +: DATA_W] = act_fn(bus.in_data[k*DATA_W +: DATA_W], cfg_mode, cfg_clip);
      s2_next[k*OUT_W +: OUT_W]   = sat_fn(s1_data[k*DATA_W +: DATA_W]);
      sat_any = sat_any | sat_hit(s1_data[k*DATA_W +: DATA_W]);
    end
  end

  // Two-stage pipeline; both stages move together only on adv
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (adv) begin
      s1_valid <= in_fire;
      s1_data  <= s1_next;
      s2_valid <= s1_valid;
      s2_data  <= s2_next;
    end
  end

  // Frame FSM, beat counters, config latch and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_cnt   <= '0;
      out_cnt  <= '0;
      cfg_mode <= 2'd0;
      cfg_clip <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (out_fire) out_cnt <= out_cnt + CNT_W'(1);
      if (adv && s1_valid && sat_any) sat_q <= 1'b1;
      case (state)
        IDLE: if (bus.start) begin
          state    <= RUN;
          cfg_mode <= bus.mode;
          cfg_clip <= bus.clip_val;
          in_cnt   <= '0;
          out_cnt  <= '0;
          busy_q   <= 1'b1;
          sat_q    <= 1'b0;
        end
        RUN: if (in_fire) begin
          in_cnt <= in_cnt + CNT_W'(1);
          if (in_cnt == CNT_W'(FRAME_LEN - 1)) state <= DRAIN;
        end
        DRAIN: if (out_fire && out_last_w) begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
